mux_scan_capture: RTL and testbench



---
 rtl/mux_scan_capture_pkg.sv | 37 +++
 rtl/mux_scan_capture_if.sv | 41 ++++
 rtl/mux_scan_capture_rate_divider.sv | 47 ++++
 rtl/mux_scan_capture.sv | 118 +++++++++++
 tb/tb_mux_scan_capture.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_capture_pkg.sv
// ============================================================================
// Module : mux_scan_capture_pkg
// Brief  : Shared encodings and widths for the mux7to1 scan/capture path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mux_scan_capture_pkg;

  localparam int NUM_IN = 7;
  localparam int SEL_W  = 3;
  localparam int DIV_W  = 16;

  localparam logic [SEL_W-1:0] FIRST_SEL = 3'd0;
  localparam logic [SEL_W-1:0] LAST_SEL  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  // Returns the word with the sample for select code sel replaced by b.
  function automatic logic [NUM_IN-1:0] put_sample(
    input logic [NUM_IN-1:0] word,
    input logic [SEL_W-1:0]  sel,
    input logic              b
  );
    logic [NUM_IN-1:0] r;
    r      = word;
    r[sel] = b;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_scan_capture_if.sv
// ============================================================================
// Module : mux_scan_capture_if
// Brief  : Control, mux-path and result signals of the scan/capture sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mux_scan_capture_if;
  import mux_scan_capture_pkg::*;

  logic              start;
  logic              continuous;
  logic              mux_out;
  logic [SEL_W-1:0]  mux_select;
  logic [NUM_IN-1:0] data_out;
  logic              done;
  logic              busy;

  modport slave (
    input  start,
    input  continuous,
    input  mux_out,
    output mux_select,
    output data_out,
    output done,
    output busy
  );

  modport master (
    output start,
    output continuous,
    output mux_out,
    input  mux_select,
    input  data_out,
    input  done,
    input  busy
  );

endinterface

`default_nettype wire

// File: rtl/mux_scan_capture_rate_divider.sv
// ============================================================================
// Module : rate_divider
// Brief  : Free-running 0..TICK_DIV-1 counter with a terminal-count tick.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rate_divider
  import mux_scan_capture_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST_COUNT = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  assign tick = enable && (count_q == LAST_COUNT);

  // Clear wins over enable so the count restarts at 0 on every scan entry.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tick ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_scan_capture.sv
// ============================================================================
// Module : mux_scan_capture
// Brief  : Steps mux7to1 select 0..6, samples its output, publishes a 7-bit word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_scan_capture
  import mux_scan_capture_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic                 clock,
  input  logic                 resetn,
  mux_scan_capture_if.slave    bus
);

  scan_state_e       state_q;
  logic [SEL_W-1:0]  sel_q;
  logic [NUM_IN-1:0] shadow_q;
  logic [NUM_IN-1:0] shadow_d;
  logic [NUM_IN-1:0] data_q;
  logic              done_q;
  logic              busy_q;

  logic              div_clear;
  logic              div_enable;
  logic              tick;

  assign div_enable = (state_q == SCAN);
  assign div_clear  = (state_q != SCAN);

  rate_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_rate_divider (
    .clock  (clock),
    .resetn (resetn),
    .clear  (div_clear),
    .enable (div_enable),
    .tick   (tick)
  );

  // Shadow including the sample being taken this cycle; on the last select
  // this is what data_out loads, so the final bit is visible in DONE.
  always_comb begin
    shadow_d = put_sample(shadow_q, sel_q, bus.mux_out);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      sel_q    <= FIRST_SEL;
      shadow_q <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sel_q  <= FIRST_SEL;
          busy_q <= 1'b0;
          if (bus.start) begin
            state_q <= SCAN;
            busy_q  <= 1'b1;
          end
        end

        SCAN: begin
          if (tick) begin
            shadow_q <= shadow_d;
            if (sel_q == LAST_SEL) begin
              state_q <= DONE;
              data_q  <= shadow_d;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              sel_q   <= FIRST_SEL;
            end else begin
              sel_q <= sel_q + 3'd1;
            end
          end
        end

        DONE: begin
          sel_q <= FIRST_SEL;
          if (bus.continuous || bus.start) begin
            state_q <= SCAN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          sel_q   <= FIRST_SEL;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mux_select = sel_q;
  assign bus.data_out   = data_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;

  // Code 7 would silently read input 0 through the mux.
  a_sel_in_range : assert property (@(posedge clock) disable iff (!resetn)
    sel_q <= LAST_SEL);

  a_done_not_busy : assert property (@(posedge clock) disable iff (!resetn)
    done_q |-> !busy_q);

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_capture.sv
// ============================================================================
// Module : tb_mux_scan_capture
// Brief  : Scoreboard bench for mux_scan_capture with a behavioural mux7to1.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_scan_capture;

  typedef struct {
    logic [6:0] word;
    int         cyc;
  } exp_t;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  logic [6:0] sw_a = 7'd0;
  logic [6:0] sw_b = 7'd0;
  logic [6:0] shown_a = 7'd0;
  logic [6:0] shown_b = 7'd0;
  exp_t       q_a[$];
  exp_t       q_b[$];
  exp_t       e_a;
  exp_t       e_b;

  mux_scan_capture_if ifa ();
  mux_scan_capture_if ifb ();

  mux_scan_capture #(.TICK_DIV(4)) u_dut_a (
    .clock  (clk),
    .resetn (resetn),
    .bus    (ifa)
  );

  mux_scan_capture #(.TICK_DIV(1)) u_dut_b (
    .clock  (clk),
    .resetn (resetn),
    .bus    (ifb)
  );

  function automatic logic mux7(input logic [6:0] in, input logic [2:0] sel);
    return (sel <= 3'd6) ? in[sel] : in[0];
  endfunction

  assign ifa.mux_out = mux7(sw_a, ifa.mux_select);
  assign ifb.mux_out = mux7(sw_b, ifb.mux_select);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Done observed at the negedge where cyc == E + 7*TICK_DIV, E being the
  // edge that sampled start.
  always begin
    @(negedge clk);
    #1;
    if (!resetn) begin
      shown_a = 7'd0;
    end else if (ifa.done) begin
      if (q_a.size() == 0) begin
        chk_eq("a_spurious_done", 32'(ifa.done), 32'd0);
      end else begin
        e_a     = q_a.pop_front();
        shown_a = e_a.word;
        chk_eq("a_done_cycle", 32'(cyc), 32'(e_a.cyc));
        chk_eq("a_done_busy", 32'(ifa.busy), 32'd0);
        chk_eq("a_done_sel", 32'(ifa.mux_select), 32'd0);
      end
    end
    chk_eq("a_data_out", 32'(ifa.data_out), 32'(shown_a));
  end

  always begin
    @(negedge clk);
    #1;
    if (!resetn) begin
      shown_b = 7'd0;
    end else if (ifb.done) begin
      if (q_b.size() == 0) begin
        chk_eq("b_spurious_done", 32'(ifb.done), 32'd0);
      end else begin
        e_b     = q_b.pop_front();
        shown_b = e_b.word;
        chk_eq("b_done_cycle", 32'(cyc), 32'(e_b.cyc));
        chk_eq("b_done_busy", 32'(ifb.busy), 32'd0);
      end
    end
    chk_eq("b_data_out", 32'(ifb.data_out), 32'(shown_b));
  end

  task automatic pulse_start(input bit which, input logic [6:0] word, input int td,
                             output int e_edge);
    exp_t e;
    @(negedge clk);
    if (which) ifb.start = 1'b1; else ifa.start = 1'b1;
    e_edge = cyc + 1;
    e.word = word;
    e.cyc  = e_edge + 7 * td;
    if (which) q_b.push_back(e); else q_a.push_back(e);
    @(negedge clk);
    if (which) ifb.start = 1'b0; else ifa.start = 1'b0;
  endtask

  task automatic wait_drain(input bit which, input int budget);
    int n = 0;
    while (((which ? q_b.size() : q_a.size()) != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk_eq(which ? "b_drain" : "a_drain", 32'(which ? q_b.size() : q_a.size()), 32'd0);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_sel_a(input logic [2:0] v, input string tag);
    int n = 0;
    while (ifa.mux_select !== v && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk_eq(tag, 32'(ifa.mux_select), 32'(v));
  endtask

  initial begin
    int e;
    ifa.start = 1'b0; ifa.continuous = 1'b0;
    ifb.start = 1'b0; ifb.continuous = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_eq("idle_sel_a", 32'(ifa.mux_select), 32'd0);
      chk_eq("idle_busy_a", 32'(ifa.busy), 32'd0);
      chk_eq("idle_done_a", 32'(ifa.done), 32'd0);
      chk_eq("idle_busy_b", 32'(ifb.busy), 32'd0);
    end

    // Single scan, TICK_DIV=4
    sw_a = 7'b1011001;
    pulse_start(1'b0, 7'b1011001, 4, e);
    for (int i = 0; i < 28; i++) begin
      if (i > 0) @(negedge clk);
      chk_eq("scan_sel", 32'(ifa.mux_select), 32'(i / 4));
      chk_eq("scan_busy", 32'(ifa.busy), 32'd1);
    end
    repeat (2) @(negedge clk);
    chk_eq("post_scan_busy", 32'(ifa.busy), 32'd0);
    chk_eq("post_scan_sel", 32'(ifa.mux_select), 32'd0);
    wait_drain(1'b0, 10);

    // Mid-scan input change: only not-yet-sampled bits follow
    sw_a = 7'b0000000;
    pulse_start(1'b0, 7'b0100000, 4, e);
    wait_sel_a(3'd3, "mid_sel_reach");
    sw_a = 7'b0100010;
    wait_drain(1'b0, 40);

    // Continuous, TICK_DIV=1
    sw_b = 7'b0101010;
    ifb.continuous = 1'b1;
    pulse_start(1'b1, 7'b0101010, 1, e);
    q_b.push_back('{7'b0101010, e + 15});
    q_b.push_back('{7'b0101010, e + 23});
    wait_cyc(e + 23);
    sw_b = 7'b1111111;
    q_b.push_back('{7'b1111111, e + 31});
    wait_cyc(e + 27);
    ifb.continuous = 1'b0;
    wait_drain(1'b1, 40);
    repeat (12) @(negedge clk);
    chk_eq("cont_stop_busy_b", 32'(ifb.busy), 32'd0);

    // Reset mid-scan after a completed 0x55 scan
    sw_a = 7'h55;
    pulse_start(1'b0, 7'h55, 4, e);
    wait_drain(1'b0, 40);
    chk_eq("pre_rst_data", 32'(ifa.data_out), 32'h55);
    sw_a = 7'h0F;
    pulse_start(1'b0, 7'h0F, 4, e);
    wait_sel_a(3'd4, "rst_sel_reach");
    resetn = 1'b0;
    #1;
    chk_eq("rst_data", 32'(ifa.data_out), 32'd0);
    chk_eq("rst_sel", 32'(ifa.mux_select), 32'd0);
    chk_eq("rst_busy", 32'(ifa.busy), 32'd0);
    chk_eq("rst_done", 32'(ifa.done), 32'd0);
    q_a.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    sw_a = 7'h2A;
    pulse_start(1'b0, 7'h2A, 4, e);
    wait_drain(1'b0, 40);

    // start held high with continuous=0: back-to-back, period 29
    sw_a = 7'b1100101;
    @(negedge clk);
    ifa.start = 1'b1;
    e = cyc + 1;
    q_a.push_back('{7'b1100101, e + 28});
    q_a.push_back('{7'b1100101, e + 57});
    q_a.push_back('{7'b1100101, e + 86});
    wait_cyc(e + 63);
    ifa.start = 1'b0;
    wait_drain(1'b0, 60);

    // start pulse during SCAN is not queued
    sw_a = 7'b0011110;
    pulse_start(1'b0, 7'b0011110, 4, e);
    wait_cyc(e + 10);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    wait_drain(1'b0, 40);
    repeat (40) @(negedge clk);
    chk_eq("no_extra_busy", 32'(ifa.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
